// File: rtl/core_seq.sv
`default_nettype none
// ============================================================================
// Module   : core_seq
// Purpose  : Autonomous instruction sequencer for the attention core. Runs
//            one K-load / Q-execute / psum-drain pass per accepted start and
//            emits the full core instruction word every cycle.
// Ports    : clk         rising-edge clock
//            reset       asynchronous, active-low reset
//            start       begin a pass (sampled in IDLE only)
//            n_k, n_q    K rows / Q vectors for the pass, legal 1..2^addr_bw
//            pause       stall FSM, counters and pending psum write
//            abort       synchronous cancel back to IDLE
//            fifo_valid  output FIFO has data
//            inst        core instruction word (registered)
//            busy        not IDLE
//            done        one-cycle pass-complete pulse
//            err         one-cycle start-rejected pulse
//            phase       current state code
// Revision : 1.0  initial release
// ============================================================================
module core_seq #(
  parameter  int col     = 8,
  parameter  int addr_bw = 4,
  localparam int inst_bw = 2 * addr_bw + 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw:0]   n_k,
  input  logic [addr_bw:0]   n_q,
  input  logic               pause,
  input  logic               abort,
  input  logic               fifo_valid,
  output logic [inst_bw-1:0] inst,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         phase
);

  localparam int CW = addr_bw + 1;
  localparam int WW = (col > 1) ? $clog2(col) : 1;

  localparam logic [CW-1:0] c_depth     = {1'b1, {addr_bw{1'b0}}};
  localparam logic [WW-1:0] c_wait_last = WW'(col - 1);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_kload = 3'd1;
  localparam logic [2:0] c_kwait = 3'd2;
  localparam logic [2:0] c_exec  = 3'd3;
  localparam logic [2:0] c_drain = 3'd4;
  localparam logic [2:0] c_fin   = 3'd5;

  // State and pass bookkeeping
  logic [2:0]    r_state;
  logic [CW-1:0] r_nk, r_nq;
  logic [CW-1:0] r_kcnt, r_qcnt, r_rcnt, r_dcnt;
  logic [WW-1:0] r_wcnt;
  logic          r_pend;        // FIFO word read, psum write still owed

  // Instruction word fields
  logic               r_kmem_rd, r_qmem_rd, r_pmem_wr, r_ofifo_rd;
  logic               r_load, r_exec;
  logic [addr_bw-1:0] r_pmem_add, r_qk_add;

  // Next-state / decision signals
  logic [2:0]         w_state_nxt;
  logic [CW-1:0]      w_nk_nxt, w_nq_nxt;
  logic [CW-1:0]      w_kcnt_nxt, w_qcnt_nxt, w_rcnt_nxt, w_dcnt_nxt;
  logic [WW-1:0]      w_wcnt_nxt;
  logic               w_pend_nxt;
  logic               w_kmem_rd, w_qmem_rd, w_pmem_wr, w_ofifo_rd;
  logic [addr_bw-1:0] w_pmem_add, w_qk_add;
  logic               w_done, w_err;
  logic               w_start_ok;
  logic [CW-1:0]      w_kinc, w_qinc, w_dinc;

  assign w_kinc = r_kcnt + 1'b1;
  assign w_qinc = r_qcnt + 1'b1;
  assign w_dinc = r_dcnt + 1'b1;

  assign w_start_ok = (n_k != '0) && (n_k <= c_depth) &&
                      (n_q != '0) && (n_q <= c_depth);

  // Decisions made in the current cycle; they become visible on inst after
  // the next rising edge. pause therefore only ever gates the decision, while
  // the lagged load/execute bits keep tracking the previous strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_nk_nxt    = r_nk;
    w_nq_nxt    = r_nq;
    w_kcnt_nxt  = r_kcnt;
    w_qcnt_nxt  = r_qcnt;
    w_rcnt_nxt  = r_rcnt;
    w_dcnt_nxt  = r_dcnt;
    w_wcnt_nxt  = r_wcnt;
    w_pend_nxt  = r_pend;
    w_kmem_rd   = 1'b0;
    w_qmem_rd   = 1'b0;
    w_pmem_wr   = 1'b0;
    w_ofifo_rd  = 1'b0;
    w_qk_add    = r_qk_add;
    w_pmem_add  = r_pmem_add;
    w_done      = 1'b0;
    w_err       = 1'b0;

    case (r_state)
      c_idle: begin
        if (start) begin
          if (w_start_ok) begin
            w_nk_nxt    = n_k;
            w_nq_nxt    = n_q;
            w_kcnt_nxt  = '0;
            w_qcnt_nxt  = '0;
            w_rcnt_nxt  = '0;
            w_dcnt_nxt  = '0;
            w_wcnt_nxt  = '0;
            w_pend_nxt  = 1'b0;
            w_state_nxt = c_kload;
          end else begin
            w_err = 1'b1;
          end
        end
      end

      c_kload: begin
        if (!pause) begin
          w_kmem_rd  = 1'b1;
          w_qk_add   = r_kcnt[addr_bw-1:0];
          w_kcnt_nxt = w_kinc;
          if (w_kinc == r_nk) begin
            w_wcnt_nxt  = '0;
            w_state_nxt = c_kwait;
          end
        end
      end

      c_kwait: begin
        if (!pause) begin
          if (r_wcnt == c_wait_last) begin
            w_state_nxt = c_exec;
          end else begin
            w_wcnt_nxt = r_wcnt + 1'b1;
          end
        end
      end

      c_exec: begin
        if (!pause) begin
          w_qmem_rd  = 1'b1;
          w_qk_add   = r_qcnt[addr_bw-1:0];
          w_qcnt_nxt = w_qinc;
          if (w_qinc == r_nq) begin
            w_state_nxt = c_drain;
          end
        end
      end

      c_drain: begin
        if (!pause) begin
          // Retire the write owed by last cycle's read first, so a new read
          // in this same cycle can re-arm the pending flag.
          if (r_pend) begin
            w_pmem_wr  = 1'b1;
            w_pmem_add = r_dcnt[addr_bw-1:0];
            w_dcnt_nxt = w_dinc;
            w_pend_nxt = 1'b0;
            if (w_dinc == r_nq) begin
              w_state_nxt = c_fin;
            end
          end
          if (fifo_valid && (r_rcnt != r_nq)) begin
            w_ofifo_rd = 1'b1;
            w_rcnt_nxt = r_rcnt + 1'b1;
            w_pend_nxt = 1'b1;
          end
        end
      end

      c_fin: begin
        if (!pause) begin
          w_done      = 1'b1;
          w_state_nxt = c_idle;
        end
      end

      default: begin
        w_state_nxt = c_idle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_idle;
      r_nk       <= '0;
      r_nq       <= '0;
      r_kcnt     <= '0;
      r_qcnt     <= '0;
      r_rcnt     <= '0;
      r_dcnt     <= '0;
      r_wcnt     <= '0;
      r_pend     <= 1'b0;
      r_kmem_rd  <= 1'b0;
      r_qmem_rd  <= 1'b0;
      r_pmem_wr  <= 1'b0;
      r_ofifo_rd <= 1'b0;
      r_load     <= 1'b0;
      r_exec     <= 1'b0;
      r_pmem_add <= '0;
      r_qk_add   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else if (abort) begin
      r_state    <= c_idle;
      r_kcnt     <= '0;
      r_qcnt     <= '0;
      r_rcnt     <= '0;
      r_dcnt     <= '0;
      r_wcnt     <= '0;
      r_pend     <= 1'b0;
      r_kmem_rd  <= 1'b0;
      r_qmem_rd  <= 1'b0;
      r_pmem_wr  <= 1'b0;
      r_ofifo_rd <= 1'b0;
      r_load     <= 1'b0;
      r_exec     <= 1'b0;
      r_pmem_add <= '0;
      r_qk_add   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_nk       <= w_nk_nxt;
      r_nq       <= w_nq_nxt;
      r_kcnt     <= w_kcnt_nxt;
      r_qcnt     <= w_qcnt_nxt;
      r_rcnt     <= w_rcnt_nxt;
      r_dcnt     <= w_dcnt_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_pend     <= w_pend_nxt;
      r_kmem_rd  <= w_kmem_rd;
      r_qmem_rd  <= w_qmem_rd;
      r_pmem_wr  <= w_pmem_wr;
      r_ofifo_rd <= w_ofifo_rd;
      // One-cycle SRAM read latency: data arrives the cycle after the strobe.
      r_load     <= r_kmem_rd;
      r_exec     <= r_qmem_rd;
      r_pmem_add <= w_pmem_add;
      r_qk_add   <= w_qk_add;
      busy       <= (w_state_nxt != c_idle);
      done       <= w_done;
      err        <= w_err;
    end
  end

  // Bits 1 (pmem_rd), 2 (kmem_wr) and 4 (qmem_wr) are never used by this pass.
  assign inst  = {r_ofifo_rd, r_qk_add, r_pmem_add, r_exec, r_load,
                  r_qmem_rd, 1'b0, r_kmem_rd, 1'b0, 1'b0, r_pmem_wr};
  assign phase = r_state;

endmodule
`default_nettype wire

// File: tb/tb_core_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_seq
// Purpose  : Self-checking bench for core_seq. A queue-of-work-items
//            reference model predicts inst/busy/done/err/phase every cycle;
//            directed passes plus randomized passes exercise it.
// Revision : 1.0  initial release
// ============================================================================
module tb_core_seq;

  localparam int COL   = 8;
  localparam int ABW   = 4;
  localparam int DEPTH = 1 << ABW;
  localparam int IBW   = 2 * ABW + 9;

  logic           clk;
  logic           reset;
  logic           start;
  logic [ABW:0]   n_k, n_q;
  logic           pause, abort, fifo_valid;
  logic [IBW-1:0] inst;
  logic           busy, done, err;
  logic [2:0]     phase;

  core_seq #(.col(COL), .addr_bw(ABW)) dut (
    .clk(clk), .reset(reset), .start(start), .n_k(n_k), .n_q(n_q),
    .pause(pause), .abort(abort), .fifo_valid(fifo_valid),
    .inst(inst), .busy(busy), .done(done), .err(err), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A pass is a list of work items, each consuming one unpaused cycle:
  // kind 1 = K row read, 2 = settle slot, 3 = Q vector read,
  // 4 = drain (stays at the head until all psums are written), 5 = finish.
  int       work[$];
  int       m_nq, m_rcnt, m_wcnt;
  bit       m_pend;
  bit       m_k, m_q, m_load, m_exec, m_wr, m_rd, m_done, m_err;
  logic [ABW-1:0] m_qk, m_padd;

  function automatic int fk();
    return (work.size() != 0) ? work[0] / 1024 : 0;
  endfunction

  task automatic model_reset();
    work.delete();
    m_nq = 0; m_rcnt = 0; m_wcnt = 0; m_pend = 0;
    m_k = 0; m_q = 0; m_load = 0; m_exec = 0; m_wr = 0; m_rd = 0;
    m_done = 0; m_err = 0; m_qk = '0; m_padd = '0;
  endtask

  task automatic model_step(input bit st, input int nk, input int nq,
                            input bit pa, input bit ab, input bit fv);
    bit pk, pq;
    int it;
    pk = m_k; pq = m_q;
    m_k = 0; m_q = 0; m_wr = 0; m_rd = 0; m_done = 0; m_err = 0;
    m_load = pk; m_exec = pq;
    if (ab) begin
      work.delete();
      m_pend = 0; m_load = 0; m_exec = 0; m_qk = '0; m_padd = '0;
    end else if (work.size() == 0) begin
      if (st) begin
        if (nk >= 1 && nk <= DEPTH && nq >= 1 && nq <= DEPTH) begin
          for (int a = 0; a < nk; a++) work.push_back(1 * 1024 + a);
          for (int a = 0; a < COL; a++) work.push_back(2 * 1024);
          for (int a = 0; a < nq; a++) work.push_back(3 * 1024 + a);
          work.push_back(4 * 1024);
          work.push_back(5 * 1024);
          m_nq = nq; m_rcnt = 0; m_wcnt = 0; m_pend = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (!pa) begin
      it = work[0];
      case (it / 1024)
        1: begin m_k = 1; m_qk = it[ABW-1:0]; void'(work.pop_front()); end
        2: void'(work.pop_front());
        3: begin m_q = 1; m_qk = it[ABW-1:0]; void'(work.pop_front()); end
        4: begin
          if (m_pend) begin
            m_wr = 1; m_padd = m_wcnt[ABW-1:0]; m_wcnt++; m_pend = 0;
            if (m_wcnt == m_nq) void'(work.pop_front());
          end
          if (fv && m_rcnt < m_nq) begin
            m_rd = 1; m_rcnt++; m_pend = 1;
          end
        end
        default: begin m_done = 1; void'(work.pop_front()); end
      endcase
    end
  endtask

  function automatic logic [IBW-1:0] exp_inst();
    return {m_rd, m_qk, m_padd, m_exec, m_load, m_q, 1'b0, m_k, 2'b00, m_wr};
  endfunction

  // ---------------- stimulus ----------------
  int      done_seen, rd_seen;
  int      wr_addrs[$];

  task automatic step(input bit st, input int nk, input int nq,
                      input bit pa, input bit ab, input bit fv);
    @(negedge clk);
    start = st; n_k = nk[ABW:0]; n_q = nq[ABW:0];
    pause = pa; abort = ab; fifo_valid = fv;
    @(posedge clk);
    model_step(st, nk, nq, pa, ab, fv);
    #1;
    cyc++;
    check("inst", inst, exp_inst());
    check("ctl", {busy, done, err, phase},
          {(work.size() != 0), m_done, m_err, 3'(fk())});
    if (done) done_seen++;
    if (inst[IBW-1]) rd_seen++;
    if (inst[0]) wr_addrs.push_back(int'(inst[8 +: ABW]));
  endtask

  int pp = 0, fp = 100;
  bit stall_pat[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  // mode 0 plain, 1 pause x3 mid-EXEC, 2 drain stall, 3 start while busy, 4 random
  task automatic run_pass(input int nk, input int nq, input int mode, output int len);
    int pc, di, lim;
    bit pa, fv, st;
    pc = 0; di = 0; lim = 0;
    done_seen = 0; rd_seen = 0; wr_addrs.delete();
    step(1'b1, nk, nq, 1'b0, 1'b0, 1'b0);
    len = 1;
    while (work.size() != 0 && lim < 1000) begin
      pa = 0; st = 0; fv = (fk() >= 3);
      case (mode)
        1: if (fk() == 3 && work[0] % 1024 == 1 && pc < 3) begin pa = 1; pc++; end
        2: if (fk() == 4) begin fv = (di < 5) ? stall_pat[di] : 1'b1; di++; end
        3: st = (lim % 5 == 2);
        4: begin
          pa = ($urandom % 100) < pp;
          fv = ($urandom % 100) < fp;
          st = ($urandom % 16) == 0;
        end
        default: ;
      endcase
      step(st, (mode == 3) ? 3 : nk, nq, pa, 1'b0, fv);
      len++; lim++;
    end
    if (work.size() != 0) begin
      check("pass_timeout", 1, 0);
      step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic pass_checks(input int nq, input int exp_done);
    check("done_cnt", done_seen, exp_done);
    check("rd_cnt", rd_seen, nq);
    check("wr_cnt", wr_addrs.size(), nq);
    for (int i = 0; i < wr_addrs.size(); i++) check("wr_addr", wr_addrs[i], i);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int len0, len1, len, lim, nk, nq;
    bit legal;
    reset = 1'b0; start = 1'b0; n_k = '0; n_q = '0;
    pause = 1'b0; abort = 1'b0; fifo_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_inst", inst, 0);
    check("rst_ctl", {busy, done, err, phase}, 0);
    @(negedge clk) reset = 1'b1;

    // Illegal starts
    step(1'b1, 0, 3, 1'b0, 1'b0, 1'b0);
    check("err_nk0", err, 1);
    step(1'b1, 3, 17, 1'b0, 1'b0, 1'b0);
    check("err_nq17", err, 1);
    check("illegal_inst", inst, 0);
    check("illegal_phase", phase, 0);
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);   // pause in IDLE: nothing happens

    // Basic pass, then the same with a 3-cycle pause mid-EXEC
    run_pass(2, 3, 0, len0);
    pass_checks(3, 1);
    run_pass(2, 3, 1, len1);
    pass_checks(3, 1);
    check("pause_len", len1, len0 + 3);

    // Drain stall
    run_pass(3, 3, 2, len);
    pass_checks(3, 1);

    // Abort during KWAIT, then a clean pass
    done_seen = 0;
    step(1'b1, 4, 2, 1'b0, 1'b0, 1'b0);
    lim = 0;
    while (fk() != 2 && lim < 50) begin step(1'b0, 4, 2, 1'b0, 1'b0, 1'b0); lim++; end
    step(1'b0, 4, 2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4, 2, 1'b0, 1'b1, 1'b0);
    check("abort_phase", phase, 0);
    check("abort_busy", busy, 0);
    step(1'b0, 4, 2, 1'b0, 1'b0, 1'b0);
    check("abort_no_done", done_seen, 0);
    run_pass(4, 2, 0, len);
    pass_checks(2, 1);

    // Full depth, with start pulses while busy
    run_pass(DEPTH, DEPTH, 3, len);
    pass_checks(DEPTH, 1);

    // Asynchronous reset during DRAIN
    step(1'b1, 1, 2, 1'b0, 1'b0, 1'b0);
    lim = 0;
    while (fk() != 4 && lim < 100) begin step(1'b0, 1, 2, 1'b0, 1'b0, 1'b0); lim++; end
    step(1'b0, 1, 2, 1'b0, 1'b0, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("rstmid_inst", inst, 0);
    check("rstmid_ctl", {busy, done, err, phase}, 0);
    model_reset();
    @(negedge clk) reset = 1'b1;
    run_pass(2, 2, 0, len);
    pass_checks(2, 1);

    // Randomized passes
    for (int r = 0; r < 14; r++) begin
      nk = ($urandom % 8 == 0) ? $urandom_range(17, 31) : $urandom_range(1, DEPTH);
      nq = ($urandom % 8 == 0) ? 0 : $urandom_range(1, DEPTH);
      pp = $urandom_range(0, 30);
      fp = $urandom_range(30, 100);
      legal = (nk >= 1 && nk <= DEPTH && nq >= 1 && nq <= DEPTH);
      run_pass(nk, nq, 4, len);
      pass_checks(legal ? nq : 0, legal ? 1 : 0);
      repeat ($urandom_range(0, 3)) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
